// File: rtl/out_fifo_drain_pkg.sv
// Shared types and default sizes for the FIFO drain block.
package out_fifo_drain_pkg;

    localparam int DEF_DATA_WIDTH = 4;
    localparam int DEF_CNT_WIDTH  = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } drain_state_e;

endpackage

// File: rtl/out_fifo_drain_skid.sv
// Two-entry in-order skid buffer; entry 0 is always the head presented downstream.
module out_fifo_drain_skid
    import out_fifo_drain_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] head,
    output logic [1:0]            occ
);

    logic [DATA_WIDTH-1:0] entry_reg  [2];
    logic [DATA_WIDTH-1:0] entry_next [2];
    logic [1:0]            occ_reg;
    logic [1:0]            occ_next;
    logic                  pop_ok;
    logic                  wr_sel;

    assign pop_ok = pop && (occ_reg != 2'd0);
    // Slot the incoming word lands in after any shift caused by a pop.
    assign wr_sel = pop_ok ? (occ_reg == 2'd2) : (occ_reg != 2'd0);

    always_comb begin
        occ_next = occ_reg + {1'b0, push} - {1'b0, pop_ok};
        for (int i = 0; i < 2; i++) begin
            entry_next[i] = entry_reg[i];
        end
        if (pop_ok) begin
            entry_next[0] = entry_reg[1];
        end
        if (push) begin
            entry_next[wr_sel] = push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ_reg <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                entry_reg[i] <= '0;
            end
        end else begin
            occ_reg <= occ_next;
            for (int i = 0; i < 2; i++) begin
                entry_reg[i] <= entry_next[i];
            end
        end
    end

    assign head = entry_reg[0];
    assign occ  = occ_reg;

endmodule

// File: rtl/out_fifo_drain.sv
// Drains an upstream FIFO (1-cycle read latency) into a valid/ready consumer
// through a 2-entry skid buffer, with run/drain control and read statistics.
module out_fifo_drain
    import out_fifo_drain_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_q,
    output logic                  fifo_rden,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  dout_valid,
    input  logic                  dout_ready,
    output logic [1:0]            state,
    output logic                  underrun,
    output logic [CNT_WIDTH-1:0]  rd_count
);

    drain_state_e         state_reg;
    logic                 inflight_reg;
    logic                 underrun_reg;
    logic [CNT_WIDTH-1:0] rd_count_reg;
    logic [1:0]           occ;
    logic                 pop;
    logic [2:0]           fill_after;

    assign dout_valid = (occ != 2'd0);
    assign pop        = dout_valid && dout_ready;

    // Buffer fill once the in-flight word lands; a new read needs a free slot then.
    assign fill_after = {1'b0, occ} + {2'b00, inflight_reg} - {2'b00, pop};
    assign fifo_rden  = (state_reg == RUN) && !fifo_empty && (fill_after < 3'd2);

    out_fifo_drain_skid #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid (
        .clk       (clk),
        .rst       (reset),
        .push      (inflight_reg),
        .push_data (fifo_q),
        .pop       (pop),
        .head      (dout),
        .occ       (occ)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= IDLE;
            inflight_reg <= 1'b0;
            underrun_reg <= 1'b0;
            rd_count_reg <= '0;
        end else begin
            inflight_reg <= fifo_rden;
            if (fifo_rden) begin
                rd_count_reg <= rd_count_reg + CNT_WIDTH'(1);
            end
            case (state_reg)
                IDLE: begin
                    if (enable) begin
                        state_reg    <= RUN;
                        underrun_reg <= 1'b0;
                    end
                end
                RUN: begin
                    if (dout_ready && !dout_valid) begin
                        underrun_reg <= 1'b1;
                    end
                    if (!enable) begin
                        state_reg <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (enable) begin
                        state_reg <= RUN;
                    end else if (!inflight_reg && (occ == 2'd0)) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign state    = state_reg;
    assign underrun = underrun_reg;
    assign rd_count = rd_count_reg;

endmodule

// File: tb/tb_out_fifo_drain.sv
// Self-checking bench: queue-based FIFO/consumer model with a decoupled scoreboard monitor.
module tb_out_fifo_drain;

    localparam int DW = 4;
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          enable = 1'b0;
    logic          fifo_empty = 1'b1;
    logic          dout_ready = 1'b0;
    logic [DW-1:0] fifo_q = '0;
    logic          fifo_rden, dout_valid, underrun;
    logic [DW-1:0] dout;
    logic [1:0]    state;
    logic [15:0]   rd_count;
    logic          w_rden, w_valid, w_underrun;
    logic [DW-1:0] w_dout;
    logic [1:0]    w_state;
    logic [3:0]    rd_count4;

    always #5 clk = ~clk;

    out_fifo_drain #(.DATA_WIDTH(DW), .CNT_WIDTH(16)) dut (
        .clk(clk), .reset(reset), .enable(enable), .fifo_empty(fifo_empty),
        .fifo_q(fifo_q), .fifo_rden(fifo_rden), .dout(dout), .dout_valid(dout_valid),
        .dout_ready(dout_ready), .state(state), .underrun(underrun), .rd_count(rd_count)
    );

    out_fifo_drain #(.DATA_WIDTH(DW), .CNT_WIDTH(4)) dut_w (
        .clk(clk), .reset(reset), .enable(enable), .fifo_empty(fifo_empty),
        .fifo_q(fifo_q), .fifo_rden(w_rden), .dout(w_dout), .dout_valid(w_valid),
        .dout_ready(dout_ready), .state(w_state), .underrun(w_underrun), .rd_count(rd_count4)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Upstream FIFO contents and scoreboard of words owed to the consumer.
    logic [DW-1:0] src_q[$];
    logic [DW-1:0] exp_q[$];
    bit enable_drv  = 1'b0;
    bit force_empty = 1'b0;
    int ready_mode  = 0;
    bit rden_prev   = 1'b0;
    bit last_xfer   = 1'b0;
    int cyc         = 0;

    task automatic cycle();
        @(negedge clk);
        cyc++;
        if (rden_prev && src_q.size() > 0) begin
            fifo_q = src_q.pop_front();
            exp_q.push_back(fifo_q);
        end else begin
            fifo_q = DW'($urandom);
        end
        enable = enable_drv;
        case (ready_mode)
            0:       dout_ready = 1'b0;
            1:       dout_ready = 1'b1;
            2:       dout_ready = dout_valid;
            default: dout_ready = 1'($urandom_range(0, 1));
        endcase
        fifo_empty = force_empty || (src_q.size() == 0);
        #1;
        rden_prev = fifo_rden;
        last_xfer = dout_valid && dout_ready;
        if (fifo_empty) check_eq("rden_while_empty", int'(fifo_rden), 0);
    endtask

    task automatic go_idle(input string name);
        int k;
        k = 0;
        enable_drv  = 1'b0;
        ready_mode  = 1;
        force_empty = 1'b0;
        while (!(state == S_IDLE && !dout_valid) && k < 60) begin
            cycle();
            k++;
        end
        check_eq({name, "_reach_idle"}, int'(k < 60), 1);
        src_q.delete();
    endtask

    // Monitor: high-level model of state, underrun, counts and delivered words.
    logic [1:0]    m_state = S_IDLE;
    logic [1:0]    m_next;
    bit            m_ur = 1'b0;
    logic [15:0]   m_rd = '0;
    int            m_outstanding = 0;
    bit            m_prev_rden = 1'b0;
    bit            m_hold = 1'b0;
    logic [DW-1:0] m_hold_dout = '0;
    bit            m_xfer;
    logic [DW-1:0] m_exp;

    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (reset) begin
                m_state = S_IDLE; m_ur = 1'b0; m_rd = '0; m_outstanding = 0;
                m_prev_rden = 1'b0; m_hold = 1'b0;
                continue;
            end
            check_eq("state", int'(state), int'(m_state));
            check_eq("underrun", int'(underrun), int'(m_ur));
            check_eq("rd_count", int'(rd_count), int'(m_rd));
            check_eq("rd_count_w4", int'(rd_count4), int'(m_rd[3:0]));
            check_eq("dout_valid", int'(dout_valid), int'((m_outstanding - int'(m_prev_rden)) > 0));
            if (m_hold) begin
                check_eq("hold_valid", int'(dout_valid), 1);
                check_eq("hold_dout", int'(dout), int'(m_hold_dout));
            end
            m_xfer = dout_valid && dout_ready;
            if (m_xfer) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL dout: got word %0d, expected no word", dout);
                end else begin
                    m_exp = exp_q.pop_front();
                    check_eq("dout", int'(dout), int'(m_exp));
                end
            end
            case (m_state)
                S_IDLE:  m_next = enable ? S_RUN : S_IDLE;
                S_RUN:   m_next = enable ? S_RUN : S_DRAIN;
                default: m_next = enable ? S_RUN : ((m_outstanding == 0) ? S_IDLE : S_DRAIN);
            endcase
            if (m_state == S_RUN && dout_ready && !dout_valid) m_ur = 1'b1;
            if (m_state == S_IDLE && m_next == S_RUN) m_ur = 1'b0;
            m_outstanding += int'(fifo_rden) - int'(m_xfer);
            m_prev_rden = fifo_rden;
            if (fifo_rden) m_rd++;
            m_hold = dout_valid && !dout_ready;
            m_hold_dout = dout;
            m_state = m_next;
        end
    end

    initial begin
        int run_len, max_run, nx, nr, first_x, last_x, k;
        bit seen_drain, got_first;
        logic [DW-1:0] first_word, first_dout;

        #1 reset = 1'b1;
        #1;
        check_eq("rst_rden", int'(fifo_rden), 0);
        check_eq("rst_dout", int'(dout), 0);
        check_eq("rst_valid", int'(dout_valid), 0);
        check_eq("rst_state", int'(state), 0);
        check_eq("rst_underrun", int'(underrun), 0);
        check_eq("rst_rd_count", int'(rd_count), 0);
        cycle();
        cycle();
        reset = 1'b0;

        // Streaming 1..8 with consumer always taking presented words.
        for (int i = 1; i <= 8; i++) src_q.push_back(DW'(i));
        enable_drv = 1'b1; ready_mode = 2; force_empty = 1'b0;
        run_len = 0; max_run = 0; nx = 0; first_x = -1; last_x = -1;
        for (int i = 0; i < 30; i++) begin
            cycle();
            if (rden_prev) begin
                run_len++;
                if (run_len > max_run) max_run = run_len;
            end else begin
                run_len = 0;
            end
            if (last_xfer) begin
                nx++;
                if (first_x < 0) first_x = cyc;
                last_x = cyc;
            end
        end
        check_eq("stream_rden_run", max_run, 8);
        check_eq("stream_words", nx, 8);
        check_eq("stream_consecutive", last_x - first_x, 7);
        check_eq("stream_rd_count", int'(rd_count), 8);
        check_eq("stream_underrun", int'(underrun), 0);
        go_idle("stream");

        // Backpressure: only two reads fit, head word held.
        for (int i = 1; i <= 3; i++) src_q.push_back(DW'(i));
        enable_drv = 1'b1; ready_mode = 0; nr = 0;
        for (int i = 0; i < 10; i++) begin
            cycle();
            nr += int'(rden_prev);
        end
        check_eq("bp_reads", nr, 2);
        check_eq("bp_valid", int'(dout_valid), 1);
        check_eq("bp_dout", int'(dout), 1);
        ready_mode = 1; nx = 0;
        for (int i = 0; i < 10; i++) begin
            cycle();
            nx += int'(last_xfer);
        end
        check_eq("bp_delivered", nx, 3);
        go_idle("bp");

        // Empty FIFO while running: starvation flag, sticky until re-entry to RUN.
        for (int i = 0; i < 4; i++) src_q.push_back(DW'($urandom));
        enable_drv = 1'b1; force_empty = 1'b1; ready_mode = 1; nr = 0;
        for (int i = 0; i < 6; i++) begin
            cycle();
            nr += int'(rden_prev);
        end
        check_eq("empty_reads", nr, 0);
        check_eq("empty_underrun", int'(underrun), 1);
        enable_drv = 1'b0; ready_mode = 0;
        for (int i = 0; i < 4; i++) cycle();
        check_eq("empty_idle_state", int'(state), int'(S_IDLE));
        check_eq("empty_underrun_sticky", int'(underrun), 1);
        enable_drv = 1'b1;
        cycle();
        cycle();
        check_eq("reenable_state", int'(state), int'(S_RUN));
        check_eq("reenable_underrun", int'(underrun), 0);
        go_idle("empty");

        // Disable while a read is being issued.
        for (int i = 0; i < 6; i++) src_q.push_back(DW'(i + 9));
        enable_drv = 1'b1; ready_mode = 2; nr = 0; nx = 0; k = 0;
        while (nr < 2 && k < 20) begin
            cycle();
            nr += int'(rden_prev);
            nx += int'(last_xfer);
            k++;
        end
        check_eq("dis_start", int'(k < 20), 1);
        enable_drv = 1'b0;
        cycle();
        nx += int'(last_xfer);
        check_eq("dis_rden_at_drop", int'(rden_prev), 1);
        nr = 0; k = 0; seen_drain = 1'b0;
        while (state != S_IDLE && k < 20) begin
            cycle();
            nr += int'(rden_prev);
            nx += int'(last_xfer);
            if (state == S_DRAIN) seen_drain = 1'b1;
            k++;
        end
        check_eq("dis_reach_idle", int'(k < 20), 1);
        check_eq("dis_seen_drain", int'(seen_drain), 1);
        check_eq("dis_no_more_reads", nr, 0);
        check_eq("dis_delivered", nx, 3);
        src_q.delete();

        // Reset with a full buffer, then resume and wrap the 4-bit counter.
        for (int i = 0; i < 5; i++) src_q.push_back(DW'($urandom));
        enable_drv = 1'b1; ready_mode = 0;
        for (int i = 0; i < 8; i++) cycle();
        check_eq("mid_full_valid", int'(dout_valid), 1);
        reset = 1'b1;
        #1;
        check_eq("mid_rst_rden", int'(fifo_rden), 0);
        check_eq("mid_rst_dout", int'(dout), 0);
        check_eq("mid_rst_valid", int'(dout_valid), 0);
        check_eq("mid_rst_state", int'(state), 0);
        check_eq("mid_rst_underrun", int'(underrun), 0);
        check_eq("mid_rst_rd_count", int'(rd_count), 0);
        check_eq("mid_rst_rd_count4", int'(rd_count4), 0);
        exp_q.delete();
        rden_prev = 1'b0;
        enable_drv = 1'b0;
        cycle();
        reset = 1'b0;
        first_word = src_q[0];
        for (int i = 0; i < 14; i++) src_q.push_back(DW'($urandom));
        enable_drv = 1'b1; ready_mode = 1; k = 0; got_first = 1'b0; first_dout = '0;
        while (!(src_q.size() == 0 && exp_q.size() == 0 && !dout_valid) && k < 80) begin
            cycle();
            if (last_xfer && !got_first) begin
                got_first = 1'b1;
                first_dout = dout;
            end
            k++;
        end
        check_eq("mid_resume_done", int'(k < 80), 1);
        check_eq("mid_first_word", int'(first_dout), int'(first_word));
        check_eq("wrap_rd_count", int'(rd_count), 17);
        check_eq("wrap_rd_count4", int'(rd_count4), 1);
        go_idle("mid");

        // Randomised traffic against the model.
        enable_drv = 1'b1; ready_mode = 3;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 19) == 0) enable_drv = !enable_drv;
            force_empty = ($urandom_range(0, 3) == 0);
            while (src_q.size() < 4) src_q.push_back(DW'($urandom));
            cycle();
        end
        go_idle("rand");
        cycle();
        check_eq("final_scoreboard_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
